// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes WIDTH-bit operands
// DIGIT bits per clock. It uses a short chain of full-adder cells and a
// registered carry between digits, with a start/busy/done handshake and
// registered carry-out and signed-overflow flags.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Refuse to elaborate with operand/digit widths that cannot be processed evenly
  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             busy_reg;
  logic             done_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] s_shift;

  // Ripple the registered carry through DIGIT full-adder cells on the low operand bits
  always_comb begin
    dsum     = '0;
    chain    = '0;
    chain[0] = carry_reg;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]      = a_reg[i] ^ b_reg[i] ^ chain[i];
      chain[i+1]   = (a_reg[i] & b_reg[i]) | (a_reg[i] & chain[i]) | (b_reg[i] & chain[i]);
    end
  end

  // New digit sum bits enter the result register from the MSB end
  generate
    if (DIGIT >= WIDTH) begin : g_shift_full
      assign s_shift = dsum[WIDTH-1:0];
    end else begin : g_shift_part
      assign s_shift = {dsum, s_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Control FSM and datapath registers; the final digit registers the flags and pulses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= cin ^ sub;
            cnt       <= '0;
            busy_reg  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          s_reg     <= s_shift;
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= chain[DIGIT];
          if (cnt == LAST) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            cout_reg <= chain[DIGIT];
            ovf_reg  <= chain[DIGIT-1] ^ chain[DIGIT];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign s    = s_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder in several WIDTH/DIGIT
// configurations, covering reset, latency, flags, handshake, mid-op reset and
// a reference-model sweep.
module tb_serial_adder;

  logic clk;
  logic rst;

  int checks;
  int failures;

  // W8 D1 instance
  logic       start_1, cin_1, sub_1, busy_1, done_1, cout_1, ovf_1;
  logic [7:0] a_1, b_1, s_1;
  // W8 D4 instance
  logic       start_4, cin_4, sub_4, busy_4, done_4, cout_4, ovf_4;
  logic [7:0] a_4, b_4, s_4;
  // W1 D1 instance
  logic       start_w1, cin_w1, sub_w1, busy_w1, done_w1, cout_w1, ovf_w1;
  logic [0:0] a_w1, b_w1, s_w1;
  // W8 D2 instance
  logic       start_2, cin_2, sub_2, busy_2, done_2, cout_2, ovf_2;
  logic [7:0] a_2, b_2, s_2;
  // W16 D4 instance
  logic        start_16, cin_16, sub_16, busy_16, done_16, cout_16, ovf_16;
  logic [15:0] a_16, b_16, s_16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut_w8d1 (
    .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1), .cin(cin_1), .sub(sub_1),
    .busy(busy_1), .done(done_1), .s(s_1), .cout(cout_1), .ovf(ovf_1));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut_w8d4 (
    .clk(clk), .rst(rst), .start(start_4), .a(a_4), .b(b_4), .cin(cin_4), .sub(sub_4),
    .busy(busy_4), .done(done_4), .s(s_4), .cout(cout_4), .ovf(ovf_4));

  serial_adder #(.WIDTH(1), .DIGIT(1)) dut_w1d1 (
    .clk(clk), .rst(rst), .start(start_w1), .a(a_w1), .b(b_w1), .cin(cin_w1), .sub(sub_w1),
    .busy(busy_w1), .done(done_w1), .s(s_w1), .cout(cout_w1), .ovf(ovf_w1));

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut_w8d2 (
    .clk(clk), .rst(rst), .start(start_2), .a(a_2), .b(b_2), .cin(cin_2), .sub(sub_2),
    .busy(busy_2), .done(done_2), .s(s_2), .cout(cout_2), .ovf(ovf_2));

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut_w16d4 (
    .clk(clk), .rst(rst), .start(start_16), .a(a_16), .b(b_16), .cin(cin_16), .sub(sub_16),
    .busy(busy_16), .done(done_16), .s(s_16), .cout(cout_16), .ovf(ovf_16));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset values of every instance while rst is held
  task automatic test_reset();
    rst = 1'b0;
    start_1 = 0; a_1 = 0; b_1 = 0; cin_1 = 0; sub_1 = 0;
    start_4 = 0; a_4 = 0; b_4 = 0; cin_4 = 0; sub_4 = 0;
    start_w1 = 0; a_w1 = 0; b_w1 = 0; cin_w1 = 0; sub_w1 = 0;
    start_2 = 0; a_2 = 0; b_2 = 0; cin_2 = 0; sub_2 = 0;
    start_16 = 0; a_16 = 0; b_16 = 0; cin_16 = 0; sub_16 = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy_1, done_1, s_1, cout_1, ovf_1} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_w8d1 got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               busy_1, done_1, s_1, cout_1, ovf_1);
    end
    checks++;
    if ({busy_16, done_16, s_16, cout_16, ovf_16} !== 20'h00000) begin
      failures++;
      $display("[TB] FAIL reset_w16d4 got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               busy_16, done_16, s_16, cout_16, ovf_16);
    end
    checks++;
    if ({busy_2, done_2, s_2, busy_4, done_4, s_4, busy_w1, done_w1, s_w1} !== 23'h0) begin
      failures++;
      $display("[TB] FAIL reset_others got d2 s=%h d4 s=%h w1 s=%h expected 0", s_2, s_4, s_w1);
    end
    rst = 1'b0;
  endtask

  // W8 D1: 0x3C + 0x45 gives 0x81 with signed overflow after 8 cycles
  task automatic test_add_w8d1();
    int lat;
    @(negedge clk);
    a_1 = 8'h3C; b_1 = 8'h45; cin_1 = 0; sub_1 = 0; start_1 = 1;
    @(negedge clk);
    start_1 = 0;
    checks++;
    if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w8d1_busy got busy=%b done=%b expected busy=1 done=0", busy_1, done_1);
    end
    lat = 0;
    while (done_1 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("[TB] FAIL w8d1_latency got %0d expected 8", lat);
    end
    checks++;
    if (s_1 !== 8'h81 || cout_1 !== 1'b0 || ovf_1 !== 1'b1 || busy_1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w8d1_result got s=%h cout=%b ovf=%b busy=%b expected s=81 cout=0 ovf=1 busy=0",
               s_1, cout_1, ovf_1, busy_1);
    end
    @(negedge clk);
    checks++;
    if (done_1 !== 1'b0 || s_1 !== 8'h81 || ovf_1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL w8d1_hold got done=%b s=%h ovf=%b expected done=0 s=81 ovf=1", done_1, s_1, ovf_1);
    end
  endtask

  // W8 D4: 0xFF+0x01+1 then 0x05-0x07, each done after 2 cycles
  task automatic test_w8d4();
    int lat;
    @(negedge clk);
    a_4 = 8'hFF; b_4 = 8'h01; cin_4 = 1; sub_4 = 0; start_4 = 1;
    @(negedge clk);
    start_4 = 0;
    lat = 0;
    while (done_4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("[TB] FAIL w8d4_latency got %0d expected 2", lat);
    end
    checks++;
    if (s_4 !== 8'h01 || cout_4 !== 1'b1 || ovf_4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w8d4_add got s=%h cout=%b ovf=%b expected s=01 cout=1 ovf=0", s_4, cout_4, ovf_4);
    end
    @(negedge clk);
    a_4 = 8'h05; b_4 = 8'h07; cin_4 = 0; sub_4 = 1; start_4 = 1;
    @(negedge clk);
    start_4 = 0;
    lat = 0;
    while (done_4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2 || s_4 !== 8'hFE || cout_4 !== 1'b0 || ovf_4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w8d4_sub got lat=%0d s=%h cout=%b ovf=%b expected lat=2 s=FE cout=0 ovf=0",
               lat, s_4, cout_4, ovf_4);
    end
  endtask

  // W1 D1: full-adder truth table over all (a, b, cin)
  task automatic test_full_adder();
    int lat;
    logic [2:0] v;
    logic exp_s, exp_c, exp_o;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp_s = v[2] ^ v[1] ^ v[0];
      exp_c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      exp_o = v[0] ^ exp_c;
      @(negedge clk);
      a_w1 = v[2]; b_w1 = v[1]; cin_w1 = v[0]; sub_w1 = 0; start_w1 = 1;
      @(negedge clk);
      start_w1 = 0;
      lat = 0;
      while (done_w1 !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1 || s_w1 !== exp_s || cout_w1 !== exp_c || ovf_w1 !== exp_o) begin
        failures++;
        $display("[TB] FAIL full_adder abc=%b got lat=%0d s=%b cout=%b ovf=%b expected lat=1 s=%b cout=%b ovf=%b",
                 v, lat, s_w1, cout_w1, ovf_w1, exp_s, exp_c, exp_o);
      end
    end
  endtask

  // W8 D2: starts during RUN are ignored; start held through done launches the next op
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a_2 = 8'h12; b_2 = 8'h34; cin_2 = 0; sub_2 = 0; start_2 = 1;
    @(negedge clk);
    a_2 = 8'hFF; b_2 = 8'hFF; sub_2 = 1; cin_2 = 1;
    @(negedge clk);
    checks++;
    if (busy_2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hs_busy_during_ignored_start got %b expected 1", busy_2);
    end
    a_2 = 8'h70; b_2 = 8'h10; cin_2 = 0; sub_2 = 0;
    lat = 1;
    while (done_2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || s_2 !== 8'h46 || cout_2 !== 1'b0 || ovf_2 !== 1'b0 || busy_2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hs_first_op got lat=%0d s=%h cout=%b ovf=%b busy=%b expected lat=4 s=46 cout=0 ovf=0 busy=0",
               lat, s_2, cout_2, ovf_2, busy_2);
    end
    @(negedge clk);
    start_2 = 0;
    checks++;
    if (busy_2 !== 1'b1 || done_2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hs_second_accept got busy=%b done=%b expected busy=1 done=0", busy_2, done_2);
    end
    lat = 0;
    while (done_2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || s_2 !== 8'h80 || cout_2 !== 1'b0 || ovf_2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hs_second_op got lat=%0d s=%h cout=%b ovf=%b expected lat=4 s=80 cout=0 ovf=1",
               lat, s_2, cout_2, ovf_2);
    end
  endtask

  // W8 D1: asynchronous reset three cycles into an operation, then a fresh op
  task automatic test_reset_mid_op();
    int lat;
    int seen_done;
    @(negedge clk);
    a_1 = 8'h55; b_1 = 8'h22; cin_1 = 0; sub_1 = 0; start_1 = 1;
    @(negedge clk);
    start_1 = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_1 !== 1'b0 || done_1 !== 1'b0 || s_1 !== 8'h00 || cout_1 !== 1'b0 || ovf_1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_async got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               busy_1, done_1, s_1, cout_1, ovf_1);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_1 === 1'b1 || busy_1 === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("[TB] FAIL rst_no_done got %0d busy/done cycles expected 0", seen_done);
    end
    a_1 = 8'h0F; b_1 = 8'h01; cin_1 = 1; sub_1 = 1; start_1 = 1;
    @(negedge clk);
    start_1 = 0;
    lat = 0;
    while (done_1 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || s_1 !== 8'h0D || cout_1 !== 1'b1 || ovf_1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_fresh_op got lat=%0d s=%h cout=%b ovf=%b expected lat=8 s=0D cout=1 ovf=0",
               lat, s_1, cout_1, ovf_1);
    end
  endtask

  // W16 D4: 1000 operations against an arithmetic reference model
  task automatic test_model_sweep();
    int lat;
    logic [15:0] ra, rb, bp;
    logic        rc, rs;
    logic [16:0] full;
    logic        exp_o;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      bp = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bp} + {16'd0, rc ^ rs};
      exp_o = (ra[15] == bp[15]) && (full[15] != ra[15]);
      @(negedge clk);
      a_16 = ra; b_16 = rb; cin_16 = rc; sub_16 = rs; start_16 = 1;
      @(negedge clk);
      start_16 = 0;
      lat = 0;
      while (done_16 !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 4 || s_16 !== full[15:0] || cout_16 !== full[16] || ovf_16 !== exp_o) begin
        failures++;
        $display("[TB] FAIL sweep a=%h b=%h cin=%b sub=%b got lat=%0d s=%h cout=%b ovf=%b expected lat=4 s=%h cout=%b ovf=%b",
                 ra, rb, rc, rs, lat, s_16, cout_16, ovf_16, full[15:0], full[16], exp_o);
      end
    end
  endtask

  // Run every scenario in order and report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_w8d1();
    test_w8d4();
    test_full_adder();
    test_back_to_back();
    test_reset_mid_op();
    test_model_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor processing WIDTH-bit operands DIGIT bits per clock through a chain of DIGIT full-adder cells and a registered carry. It trades latency for area in the arithmetic datapath. A start/busy/done handshake lets a controller issue back-to-back operations. Signed overflow and carry-out flags are reported with the result.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in (add) / borrow-in (subtract); captured on the accepted start.
- sub  input  1  0 = add, 1 = subtract; captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB (subtract: 1 = no borrow).
- ovf  output  1  signed (two's complement) overflow.

## Operation
- Let N = WIDTH/DIGIT.
- Effective operands:
  - B' = b XOR {WIDTH{sub}}.
  - C0 = cin XOR sub.
  - The result is a + B' + C0 mod 2^WIDTH.
  - sub=1, cin=0 gives a−b; sub=1, cin=1 gives a−b−1.
- FSM states:
  - IDLE: busy=0.
    - start=1 captures a, B', C0 into shift registers and a digit counter (counter := 0), then goes to RUN.
  - RUN: busy=1.
    - Each cycle adds the low DIGIT bits of the A and B' registers plus the carry register through DIGIT chained full-adder cells (s = x^y^c, carry = majority).
    - The DIGIT sum bits shift into the result register from the MSB end; the A and B' registers shift right by DIGIT.
    - The carry register takes the chain's carry-out. The counter increments.
    - On the cycle the counter equals N−1, the FSM goes to IDLE and done is asserted.
- Flags, registered on the final digit:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - For DIGIT>1 the carry into the MSB is tapped inside the chain. For DIGIT=1 it is the carry register value before the final update.
- Hold behaviour:
  - s, cout and ovf hold their value from the last completed operation until the next one completes.
  - s shows partial shift contents while busy=1 and is defined as valid only when done=1 or busy=0.
- Ignored inputs:
  - start while busy=1 is ignored; no queueing.
  - a, b, cin and sub changes while busy=1 have no effect.
- rst asserted at any time, including mid-RUN, immediately forces:
  - state IDLE, busy=0, done=0;
  - s=0, cout=0, ovf=0;
  - counter and all internal registers to 0.
  - An aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, ovf=0.
- Start accepted at rising edge k (start=1, busy=0 before the edge):
  - busy=1 from edge k to edge k+N;
  - done=1 for exactly the cycle between edges k+N and k+N+1;
  - busy=0 in that same cycle.
- Latency from accepting edge to result valid: N cycles. Examples:
  - WIDTH=8, DIGIT=1: 8 cycles.
  - WIDTH=8, DIGIT=8: 1 cycle.
- Back-to-back: start=1 during the done cycle is accepted at edge k+N+1. Sustained throughput is one result per N+1 cycles.
- done and busy are never both 1.
- Reset release: the first edge with rst=0 may accept start.

## Test plan
- WIDTH=8, DIGIT=1: a=0x3C, b=0x45, cin=0, sub=0 → done 8 cycles after accept; s=0x81, cout=0, ovf=1.
- WIDTH=8, DIGIT=4: a=0xFF, b=0x01, cin=1, sub=0 → done after 2 cycles; s=0x01, cout=1, ovf=0. Then sub=1, a=0x05, b=0x07, cin=0 → s=0xFE, cout=0, ovf=0.
- Exhaustive WIDTH=1, DIGIT=1 over all 8 (a,b,cin) combinations with sub=0 → s = a^b^cin and cout = majority, each done after 1 cycle. This matches the full-adder truth table.
- Handshake, WIDTH=8, DIGIT=2:
  - Pulse start again at cycles 1–3 of RUN → ignored; busy stays 1 and the result is from the first operands.
  - Start held high through the done cycle → second op accepted; busy rises the next cycle.
- Reset mid-op, WIDTH=8, DIGIT=1: assert rst asynchronously (between edges) 3 cycles after accept → busy, done, s, cout and ovf go to 0 without waiting for a clock edge; no done follows. A fresh start after release gives the correct result.
- Randomised check, WIDTH=16, DIGIT=4, 1000 ops with random a, b, cin, sub → s, cout and ovf match a reference model on every done pulse.
